// File: rtl/execute_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the execute stage: radix-2 shift-add
// multiply and restoring divide, one bit per cycle, with a one-cycle done pulse.
module execute_muldiv_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic [1:0]      dbg_state
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t state, state_nx;

   logic [2*XLEN-1:0] acc;
   logic [XLEN:0]     rem;
   logic [XLEN-1:0]   mcand;
   logic [CW-1:0]     cnt;
   logic [1:0]        op_q;
   logic              neg_q, rneg_q;

   logic              a_signed, b_signed, sa, sb;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, div_ovf, accept, is_div;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, prod;
   logic [XLEN+1:0]   div_shift, div_diff;
   logic              div_ge;
   logic [XLEN:0]     rem_next;
   logic [XLEN-1:0]   quo_next, quo_fin, rem_fin;

   // Operand decode: signedness per funct3, magnitudes and the special divide cases.
   always_comb begin
      is_div   = op[2];
      a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      sa       = a_signed & rs1_val[XLEN-1];
      sb       = b_signed & rs2_val[XLEN-1];
      mag_a    = sa ? -rs1_val : rs1_val;
      mag_b    = sb ? -rs2_val : rs2_val;
      div_zero = is_div && (rs2_val == '0);
      div_ovf  = is_div && !op[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
      accept   = ((state == S_IDLE) || (state == S_DONE)) && start && !flush;
   end

   // One iteration step of each datapath, plus sign-corrected final values.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
      mul_next  = {mul_sum, acc[XLEN-1:1]};
      prod      = neg_q ? -mul_next : mul_next;
      div_shift = {rem, acc[XLEN-1]};
      div_diff  = div_shift - {2'b00, mcand};
      div_ge    = !div_diff[XLEN+1];
      rem_next  = div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
      quo_next  = {acc[XLEN-2:0], div_ge};
      quo_fin   = neg_q ? -quo_next : quo_next;
      rem_fin   = rneg_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (!start)                    state_nx = S_IDLE;
               else if (!is_div)              state_nx = S_MUL;
               else if (div_zero || div_ovf)  state_nx = S_DONE;
               else                           state_nx = S_DIV;
            end
            S_MUL, S_DIV: if (cnt == '0) state_nx = S_DONE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   assign dbg_state = state;

   // Multiply keeps the multiplier in acc low half; divide keeps the shifting
   // dividend/quotient there. mcand holds the multiplicand or the divisor.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc    <= '0;
         rem    <= '0;
         mcand  <= '0;
         cnt    <= '0;
         op_q   <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         result <= '0;
         rd_out <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         busy <= (state_nx == S_MUL) || (state_nx == S_DIV);
         done <= (state_nx == S_DONE);
         if (accept) begin
            op_q   <= op[1:0];
            rd_out <= rd_in;
            cnt    <= CW'(XLEN - 1);
            neg_q  <= sa ^ sb;
            rneg_q <= sa;
            mcand  <= is_div ? mag_b : mag_a;
            acc    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            rem    <= '0;
            if (div_zero)     result <= op[1] ? rs1_val : '1;
            else if (div_ovf) result <= op[1] ? '0 : rs1_val;
         end else if (!flush && state == S_MUL) begin
            acc <= mul_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) result <= (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
         end else if (!flush && state == S_DIV) begin
            acc <= {acc[2*XLEN-1:XLEN], quo_next};
            rem <= rem_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) result <= op_q[1] ? rem_fin : quo_fin;
         end
      end
   end

endmodule
